// File: rtl/keyboard_pkg.sv
// keyboard_pkg
//   Shared definitions for the PS/2 keyboard front end: the scan codes the
//   decoder reacts to and the receive FSM state type.
package keyboard_pkg;

    // Prefix bytes
    localparam logic [7:0] SC_E0    = 8'hE0;
    localparam logic [7:0] SC_F0    = 8'hF0;

    // Fireboy keys (plain codes)
    localparam logic [7:0] SC_W     = 8'h1D;
    localparam logic [7:0] SC_A     = 8'h1C;
    localparam logic [7:0] SC_D     = 8'h23;

    // Watergirl keys (E0-prefixed codes)
    localparam logic [7:0] SC_UP    = 8'h75;
    localparam logic [7:0] SC_LEFT  = 8'h6B;
    localparam logic [7:0] SC_RIGHT = 8'h74;

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        PARITY,
        STOP
    } rx_state_t;

endpackage

// File: rtl/keyboard_controls_ps2_rx.sv
// ps2_rx
//   PS/2 device-to-host frame receiver: 2-FF synchronisers on clock and data,
//   optional ps2_clk glitch filter (PS2_GLITCH_FILTER_EN), falling-edge
//   detection, 11-bit frame FSM with odd-parity / stop-bit check and an idle
//   timeout that abandons partial frames.
//
//   Ports:
//     Clk       in   system clock
//     Reset_n   in   asynchronous active-low reset
//     ps2_clk   in   raw PS/2 clock pin
//     ps2_data  in   raw PS/2 data pin
//     rx_byte   out  last good byte (held)
//     rx_valid  out  one-cycle pulse, rx_byte updated
//     rx_err    out  one-cycle pulse, start/parity/stop/timeout error
module ps2_rx
    import keyboard_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 50000
`ifdef PS2_GLITCH_FILTER_EN
    , parameter int unsigned FILTER_CYCLES = 8
`endif
) (
    input  logic       Clk,
    input  logic       Reset_n,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] rx_byte,
    output logic       rx_valid,
    output logic       rx_err
);

    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

    logic [1:0] clk_sync;
    logic [1:0] data_sync;
    logic       clk_lvl;
    logic       clk_prev;
    logic       fall;
    logic       data_s;

    // Synchronisers idle high, matching an idle PS/2 bus.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            clk_sync  <= '1;
            data_sync <= '1;
        end else begin
            clk_sync  <= {clk_sync[0], ps2_clk};
            data_sync <= {data_sync[0], ps2_data};
        end
    end

`ifdef PS2_GLITCH_FILTER_EN
    localparam int unsigned FW = (FILTER_CYCLES > 1) ? $clog2(FILTER_CYCLES) : 1;

    logic          clk_filt;
    logic [FW-1:0] filt_cnt;

    // Output follows the synced clock only after FILTER_CYCLES consecutive
    // samples that differ from it; any agreeing sample restarts the count.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            clk_filt <= 1'b1;
            filt_cnt <= '0;
        end else if (clk_sync[1] == clk_filt) begin
            filt_cnt <= '0;
        end else if (filt_cnt == FW'(FILTER_CYCLES - 1)) begin
            clk_filt <= clk_sync[1];
            filt_cnt <= '0;
        end else begin
            filt_cnt <= filt_cnt + 1'b1;
        end
    end

    assign clk_lvl = clk_filt;
`else
    assign clk_lvl = clk_sync[1];
`endif

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            clk_prev <= 1'b1;
        end else begin
            clk_prev <= clk_lvl;
        end
    end

    assign fall   = clk_prev & ~clk_lvl;
    assign data_s = data_sync[1];

    rx_state_t     state;
    logic [2:0]    bit_cnt;
    logic [7:0]    shift;
    logic          par;
    logic [TW-1:0] tmo_cnt;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state    <= IDLE;
            bit_cnt  <= '0;
            shift    <= '0;
            par      <= 1'b0;
            tmo_cnt  <= '0;
            rx_byte  <= '0;
            rx_valid <= 1'b0;
            rx_err   <= 1'b0;
        end else begin
            rx_valid <= 1'b0;
            rx_err   <= 1'b0;
            if (fall) begin
                tmo_cnt <= '0;
                unique case (state)
                    IDLE: begin
                        if (!data_s) begin
                            state   <= DATA;
                            bit_cnt <= '0;
                        end
                    end
                    DATA: begin
                        shift   <= {data_s, shift[7:1]};
                        bit_cnt <= bit_cnt + 1'b1;
                        if (bit_cnt == 3'd7) begin
                            state <= PARITY;
                        end
                    end
                    PARITY: begin
                        par   <= data_s;
                        state <= STOP;
                    end
                    STOP: begin
                        // Odd parity: data bits plus parity carry an odd count of ones.
                        if (data_s && (^{shift, par})) begin
                            rx_byte  <= shift;
                            rx_valid <= 1'b1;
                        end else begin
                            rx_err <= 1'b1;
                        end
                        state <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end else if (state != IDLE) begin
                if (tmo_cnt == TMO_LAST) begin
                    state   <= IDLE;
                    rx_err  <= 1'b1;
                    tmo_cnt <= '0;
                end else begin
                    tmo_cnt <= tmo_cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/keyboard_controls.sv
// keyboard_controls
//   PS/2 keyboard front end producing held-key levels for the character
//   controllers (w/a/d for Fireboy, E0-prefixed up/left/right for Watergirl).
//   Optional ps2_clk glitch filter enabled by defining PS2_GLITCH_FILTER_EN.
//
//   Ports:
//     Clk                         in   50 MHz system clock
//     Reset_n                     in   asynchronous active-low reset
//     ps2_clk, ps2_data           in   raw PS/2 pins
//     w_key, a_key, d_key         out  Fireboy held levels
//     up_key, left_key, right_key out  Watergirl held levels
//     scan_code                   out  last good byte
//     scan_valid                  out  one-cycle pulse, scan_code updated
//     frame_err                   out  one-cycle pulse, frame error
module keyboard_controls
    import keyboard_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 50000
`ifdef PS2_GLITCH_FILTER_EN
    , parameter int unsigned FILTER_CYCLES = 8
`endif
) (
    input  logic       Clk,
    input  logic       Reset_n,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic       w_key,
    output logic       a_key,
    output logic       d_key,
    output logic       up_key,
    output logic       left_key,
    output logic       right_key,
    output logic [7:0] scan_code,
    output logic       scan_valid,
    output logic       frame_err
);

    logic [7:0] rx_byte;
    logic       rx_valid;
    logic       rx_err;

    ps2_rx #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
`ifdef PS2_GLITCH_FILTER_EN
        , .FILTER_CYCLES(FILTER_CYCLES)
`endif
    ) u_rx (
        .Clk      (Clk),
        .Reset_n  (Reset_n),
        .ps2_clk  (ps2_clk),
        .ps2_data (ps2_data),
        .rx_byte  (rx_byte),
        .rx_valid (rx_valid),
        .rx_err   (rx_err)
    );

    assign scan_code  = rx_byte;
    assign scan_valid = rx_valid;
    assign frame_err  = rx_err;

    logic ext;
    logic brk;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            ext       <= 1'b0;
            brk       <= 1'b0;
            w_key     <= 1'b0;
            a_key     <= 1'b0;
            d_key     <= 1'b0;
            up_key    <= 1'b0;
            left_key  <= 1'b0;
            right_key <= 1'b0;
        end else if (rx_err) begin
            // A damaged frame may have been a prefix; drop both so the next
            // byte cannot break or extend the wrong key.
            ext <= 1'b0;
            brk <= 1'b0;
        end else if (rx_valid) begin
            if (rx_byte == SC_E0) begin
                ext <= 1'b1;
            end else if (rx_byte == SC_F0) begin
                brk <= 1'b1;
            end else begin
                if (ext) begin
                    unique case (rx_byte)
                        SC_UP:    up_key    <= ~brk;
                        SC_LEFT:  left_key  <= ~brk;
                        SC_RIGHT: right_key <= ~brk;
                        default: ;
                    endcase
                end else begin
                    unique case (rx_byte)
                        SC_W: w_key <= ~brk;
                        SC_A: a_key <= ~brk;
                        SC_D: d_key <= ~brk;
                        default: ;
                    endcase
                end
                ext <= 1'b0;
                brk <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_keyboard_controls.sv
module tb_keyboard_controls;

    localparam int unsigned TMO = 50000;
    localparam int unsigned H   = 12;   // PS/2 half bit period in system clocks

    logic       Clk = 1'b0;
    logic       Reset_n = 1'b0;
    logic       ps2_clk = 1'b1;
    logic       ps2_data = 1'b1;
    logic       w_key, a_key, d_key, up_key, left_key, right_key;
    logic [7:0] scan_code;
    logic       scan_valid, frame_err;

    keyboard_controls #(.TIMEOUT_CYCLES(TMO)) dut (
        .Clk        (Clk),
        .Reset_n    (Reset_n),
        .ps2_clk    (ps2_clk),
        .ps2_data   (ps2_data),
        .w_key      (w_key),
        .a_key      (a_key),
        .d_key      (d_key),
        .up_key     (up_key),
        .left_key   (left_key),
        .right_key  (right_key),
        .scan_code  (scan_code),
        .scan_valid (scan_valid),
        .frame_err  (frame_err)
    );

    always #10 Clk = ~Clk;

    // bit order: 0 w, 1 a, 2 d, 3 up, 4 left, 5 right
    logic [5:0] keys_obs;
    assign keys_obs = {right_key, left_key, up_key, d_key, a_key, w_key};

    int total = 0;
    int bad   = 0;
    int nvalid = 0;
    int nerr   = 0;

    // Reference model state
    logic [5:0] mk = '0;
    logic       m_ext = 1'b0;
    logic       m_brk = 1'b0;
    logic [7:0] m_sc = 8'h00;
    int         exp_valid = 0;
    int         exp_err = 0;
    logic [7:0] base_codes [3] = '{8'h1D, 8'h1C, 8'h23};
    logic [7:0] ext_codes  [3] = '{8'h75, 8'h6B, 8'h74};

    always @(negedge Clk) begin
        if (scan_valid === 1'b1) nvalid++;
        if (frame_err === 1'b1) nerr++;
    end

    task automatic model_byte(input logic [7:0] b);
        if (b == 8'hE0) m_ext = 1'b1;
        else if (b == 8'hF0) m_brk = 1'b1;
        else begin
            for (int i = 0; i < 3; i++) begin
                if (!m_ext && b == base_codes[i]) mk[i] = ~m_brk;
                if (m_ext && b == ext_codes[i]) mk[i+3] = ~m_brk;
            end
            m_ext = 1'b0;
            m_brk = 1'b0;
        end
        m_sc = b;
    endtask

    task automatic send_bit(input logic b);
        ps2_data = b;
        repeat (H) @(posedge Clk);
        ps2_clk = 1'b0;
        repeat (H) @(posedge Clk);
        ps2_clk = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic bad_par);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(b[i]);
        send_bit((~^b) ^ bad_par);
        send_bit(1'b1);
        ps2_data = 1'b1;
        repeat (H) @(posedge Clk);
        #1;
    endtask

    task automatic send_good(input logic [7:0] b);
        send_frame(b, 1'b0);
        model_byte(b);
        exp_valid++;
    endtask

    task automatic send_bad(input logic [7:0] b);
        send_frame(b, 1'b1);
        m_ext = 1'b0;
        m_brk = 1'b0;
        exp_err++;
    endtask

    task automatic test_reset;
        Reset_n = 1'b0;
        repeat (3) @(posedge Clk);
        #1;
        total++; if (keys_obs !== 6'b0) begin bad++; $display("FAIL reset_keys: got %b want %b", keys_obs, 6'b0); end
        total++; if (scan_code !== 8'h00) begin bad++; $display("FAIL reset_scan_code: got %h want 00", scan_code); end
        total++; if (scan_valid !== 1'b0) begin bad++; $display("FAIL reset_scan_valid: got %b want 0", scan_valid); end
        total++; if (frame_err !== 1'b0) begin bad++; $display("FAIL reset_frame_err: got %b want 0", frame_err); end
        Reset_n = 1'b1;
        repeat (5) @(posedge Clk);
    endtask

    task automatic test_make_break;
        send_good(8'h1C);
        total++; if (keys_obs !== 6'b000010) begin bad++; $display("FAIL make_a: got %b want 000010", keys_obs); end
        total++; if (scan_code !== 8'h1C) begin bad++; $display("FAIL make_a_code: got %h want 1c", scan_code); end
        total++; if (nvalid !== exp_valid) begin bad++; $display("FAIL make_a_valid: got %0d want %0d", nvalid, exp_valid); end
        send_good(8'hF0);
        send_good(8'h1C);
        total++; if (keys_obs !== 6'b000000) begin bad++; $display("FAIL break_a: got %b want 000000", keys_obs); end
        total++; if (nvalid !== exp_valid) begin bad++; $display("FAIL break_a_valid: got %0d want %0d", nvalid, exp_valid); end
    endtask

    task automatic test_extended;
        send_good(8'hE0);
        send_good(8'h6B);
        total++; if (keys_obs !== 6'b010000) begin bad++; $display("FAIL make_left: got %b want 010000", keys_obs); end
        send_good(8'hE0);
        send_good(8'hF0);
        send_good(8'h6B);
        total++; if (keys_obs !== 6'b000000) begin bad++; $display("FAIL break_left: got %b want 000000", keys_obs); end
        send_good(8'hE0);
        send_good(8'h1D);
        total++; if (w_key !== 1'b0) begin bad++; $display("FAIL rctrl_w: got %b want 0", w_key); end
        total++; if (keys_obs !== mk) begin bad++; $display("FAIL rctrl_keys: got %b want %b", keys_obs, mk); end
    endtask

    task automatic test_parity_err;
        send_bad(8'h23);
        total++; if (nerr !== exp_err) begin bad++; $display("FAIL parity_err_count: got %0d want %0d", nerr, exp_err); end
        total++; if (nvalid !== exp_valid) begin bad++; $display("FAIL parity_no_valid: got %0d want %0d", nvalid, exp_valid); end
        total++; if (d_key !== 1'b0) begin bad++; $display("FAIL parity_d_hold: got %b want 0", d_key); end
        send_good(8'h23);
        total++; if (keys_obs !== 6'b000100) begin bad++; $display("FAIL parity_then_d: got %b want 000100", keys_obs); end
    endtask

    task automatic test_timeout;
        int waited;
        int err0;
        err0 = nerr;
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b1);
        ps2_data = 1'b1;
        waited = 0;
        while (nerr == err0 && waited < int'(TMO) + 200) begin
            @(posedge Clk);
            waited++;
        end
        #1;
        m_ext = 1'b0;
        m_brk = 1'b0;
        exp_err++;
        total++; if (nerr !== exp_err) begin bad++; $display("FAIL timeout_err: got %0d want %0d", nerr, exp_err); end
        total++; if (waited < int'(TMO) - int'(H) - 10) begin bad++; $display("FAIL timeout_early: got %0d cycles want >= %0d", waited, int'(TMO) - int'(H) - 10); end
        total++; if (nvalid !== exp_valid) begin bad++; $display("FAIL timeout_no_valid: got %0d want %0d", nvalid, exp_valid); end
        repeat (10) @(posedge Clk);
        send_good(8'h1D);
        total++; if (w_key !== 1'b1) begin bad++; $display("FAIL timeout_then_w: got %b want 1", w_key); end
        total++; if (keys_obs !== mk) begin bad++; $display("FAIL timeout_keys: got %b want %b", keys_obs, mk); end
    endtask

    task automatic test_prefix_cleanup;
        send_good(8'hF0);
        send_bad(8'h55);
        send_good(8'h1C);
        total++; if (a_key !== 1'b1) begin bad++; $display("FAIL prefix_cleanup_a: got %b want 1", a_key); end
        total++; if (keys_obs !== mk) begin bad++; $display("FAIL prefix_cleanup_keys: got %b want %b", keys_obs, mk); end
    endtask

    task automatic test_reset_mid;
        logic [7:0] b;
        b = 8'h34;
        send_good(8'h1D);
        total++; if (w_key !== 1'b1) begin bad++; $display("FAIL mid_w_held: got %b want 1", w_key); end
        send_bit(1'b0);
        for (int i = 0; i < 3; i++) send_bit(b[i]);
        ps2_data = b[3];
        repeat (H) @(posedge Clk);
        ps2_clk = 1'b0;
        repeat (H / 2) @(posedge Clk);
        #1;
        Reset_n = 1'b0;
        #1;
        total++; if (keys_obs !== 6'b0) begin bad++; $display("FAIL mid_reset_keys: got %b want 000000", keys_obs); end
        total++; if (scan_code !== 8'h00) begin bad++; $display("FAIL mid_reset_code: got %h want 00", scan_code); end
        mk = '0; m_ext = 1'b0; m_brk = 1'b0; m_sc = 8'h00;
        ps2_clk = 1'b1;
        ps2_data = 1'b1;
        repeat (4) @(posedge Clk);
        #1;
        Reset_n = 1'b1;
        repeat (10) @(posedge Clk);
        send_good(8'h23);
        total++; if (keys_obs !== 6'b000100) begin bad++; $display("FAIL mid_then_d: got %b want 000100", keys_obs); end
        total++; if (scan_code !== 8'h23) begin bad++; $display("FAIL mid_then_code: got %h want 23", scan_code); end
    endtask

`ifdef PS2_GLITCH_FILTER_EN
    task automatic test_glitch;
        int v0;
        int e0;
        v0 = nvalid;
        e0 = nerr;
        ps2_data = 1'b0;
        @(posedge Clk);
        ps2_clk = 1'b0;
        repeat (3) @(posedge Clk);
        ps2_clk = 1'b1;
        repeat (H) @(posedge Clk);
        ps2_data = 1'b1;
        repeat (H) @(posedge Clk);
        send_good(8'h74);
        total++; if (scan_code !== 8'h74) begin bad++; $display("FAIL glitch_code: got %h want 74", scan_code); end
        total++; if (nvalid !== v0 + 1) begin bad++; $display("FAIL glitch_valid: got %0d want %0d", nvalid, v0 + 1); end
        total++; if (nerr !== e0) begin bad++; $display("FAIL glitch_err: got %0d want %0d", nerr, e0); end
    endtask
`endif

    task automatic test_random;
        logic [7:0] pool [6] = '{8'h1D, 8'h1C, 8'h23, 8'h75, 8'h6B, 8'h74};
        logic [7:0] b;
        for (int g = 0; g < 25; g++) begin
            if ($urandom_range(0, 1) == 1) send_good(8'hE0);
            if ($urandom_range(0, 2) == 0) send_good(8'hF0);
            if ($urandom_range(0, 7) == 0) send_bad(8'($urandom));
            if ($urandom_range(0, 5) == 0) begin
                b = 8'($urandom);
                if (b == 8'hE0 || b == 8'hF0) b = b + 8'd1;
            end else begin
                b = pool[$urandom_range(0, 5)];
            end
            send_good(b);
            total++; if (keys_obs !== mk) begin bad++; $display("FAIL rand_keys[%0d]: got %b want %b", g, keys_obs, mk); end
            total++; if (scan_code !== m_sc) begin bad++; $display("FAIL rand_code[%0d]: got %h want %h", g, scan_code, m_sc); end
            total++; if (nvalid !== exp_valid || nerr !== exp_err) begin
                bad++;
                $display("FAIL rand_counts[%0d]: got valid=%0d err=%0d want valid=%0d err=%0d", g, nvalid, nerr, exp_valid, exp_err);
            end
        end
    endtask

    initial begin
        test_reset;
        test_make_break;
        test_extended;
        test_parity_err;
        test_timeout;
        test_prefix_cleanup;
        test_reset_mid;
`ifdef PS2_GLITCH_FILTER_EN
        test_glitch;
`endif
        test_random;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
